// File: rtl/udp_pkg.sv
// Shared types for the buffered UDP transmitter: state encoding, header layout, header-byte select.
// Latency: n/a (types and a pure function only).
// Backpressure: n/a.
package udp_pkg;

    localparam int UDP_HDR_LENGTH = 8;

    typedef enum logic [2:0] {
        IDLE,
        BUFFER,
        FOLD,
        HDR,
        PAYLOAD,
        DROP
    } state_t;

    // Index of the header byte currently presented on the output (0..7).
    typedef logic [2:0] hdr_idx_t;

    typedef struct packed {
        logic [15:0] src;
        logic [15:0] dst;
        logic [15:0] len;
        logic [15:0] csum;
    } hdr_t;

    // Header goes out big-endian, field by field.
    function automatic logic [7:0] hdr_byte(input hdr_t hdr, input hdr_idx_t idx);
        logic [7:0] b;
        case (idx)
            3'd0:    b = hdr.src[15:8];
            3'd1:    b = hdr.src[7:0];
            3'd2:    b = hdr.dst[15:8];
            3'd3:    b = hdr.dst[7:0];
            3'd4:    b = hdr.len[15:8];
            3'd5:    b = hdr.len[7:0];
            3'd6:    b = hdr.csum[15:8];
            default: b = hdr.csum[7:0];
        endcase
        return b;
    endfunction

endpackage

// File: rtl/sync_fifo.sv
// Single-clock first-word-fall-through FIFO; o_rd_dat always shows the oldest entry.
// Latency: a write is visible on o_rd_dat the cycle after it is accepted.
// Backpressure: none; the owner never writes more than DEPTH entries before draining.
// Ports: i_clk/i_reset_n, i_flush (empties the FIFO), i_wr_en/i_wr_dat, i_rd_en (pop), o_rd_dat.
module sync_fifo #(
    parameter int DEPTH = 16,
    parameter int WIDTH = 8
) (
    input  logic             i_clk,
    input  logic             i_reset_n,
    input  logic             i_flush,
    input  logic             i_wr_en,
    input  logic [WIDTH-1:0] i_wr_dat,
    input  logic             i_rd_en,
    output logic [WIDTH-1:0] o_rd_dat
);

    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
    logic [AW-1:0]    rd_ptr_q, rd_ptr_d;

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        if (i_flush) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
        end else begin
            if (i_wr_en) wr_ptr_d = wr_ptr_q + 1'b1;
            if (i_rd_en) rd_ptr_d = rd_ptr_q + 1'b1;
        end
    end

    always_ff @(posedge i_clk or negedge i_reset_n) begin
        if (!i_reset_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_wr_en && !i_flush) mem_q[wr_ptr_q] <= i_wr_dat;
    end

    assign o_rd_dat = mem_q[rd_ptr_q];

endmodule

// File: rtl/udp_tx_buffered.sv
// UDP encapsulator: buffers a whole payload, then emits 8-byte UDP header + payload; oversize packets dropped.
// Latency: first header byte valid 2 cycles after payload tlast is accepted; no bubbles while m_axis_trdy=1.
// Backpressure: m_axis_trdy stalls the registered output (data held); payload input never stalls while buffering.
// Ports: header handshake (s_udp_hdr_*), payload in (s_axis_*), packet out (m_axis_*), o_drop pulse.
// Build option: define UDP_TX_CSUM_EN to compute the checksum; otherwise the field is sent as 0x0000.
module udp_tx_buffered
    import udp_pkg::*;
#(
    parameter int AXI_DATA_WIDTH = 8,
    parameter int FIFO_DEPTH     = 2048
) (
    input  logic        i_clk,
    input  logic        i_reset_n,
    input  logic        s_udp_hdr_tvalid,
    output logic        s_udp_hdr_trdy,
    input  logic [15:0] s_udp_src_port,
    input  logic [15:0] s_udp_dst_port,
    input  logic [15:0] s_udp_pseudo_sum,
    input  logic [7:0]  s_axis_tdata,
    input  logic        s_axis_tvalid,
    input  logic        s_axis_tlast,
    output logic        s_axis_trdy,
    output logic [7:0]  m_axis_tdata,
    output logic        m_axis_tvalid,
    output logic        m_axis_tlast,
    input  logic        m_axis_trdy,
    output logic        o_drop
);

    if (AXI_DATA_WIDTH != 8) begin : g_bad_width
        $error("udp_tx_buffered: AXI_DATA_WIDTH must be 8");
    end
    if (FIFO_DEPTH < 16 || FIFO_DEPTH > 32768 || (FIFO_DEPTH & (FIFO_DEPTH - 1)) != 0) begin : g_bad_depth
        $error("udp_tx_buffered: FIFO_DEPTH must be a power of two in 16..32768");
    end

    localparam logic [15:0] DEPTH_LIMIT = 16'(FIFO_DEPTH);
    localparam hdr_idx_t    LAST_IDX    = hdr_idx_t'(UDP_HDR_LENGTH - 1);

    state_t      state_q, state_d;
    logic        rdy_en_q;
    hdr_t        hdr_q, hdr_d;
    logic [15:0] count_q, count_d;     // bytes buffered; reused as bytes left to send while draining
    hdr_idx_t    idx_q, idx_d;
    logic        out_vld_q, out_vld_d;
    logic [7:0]  out_dat_q, out_dat_d;
    logic        out_last_q, out_last_d;

    logic        fifo_wr, fifo_rd, fifo_flush;
    logic [7:0]  fifo_rdat;
    logic        out_hs;
    hdr_idx_t    idx_next;
    logic [15:0] len_calc;
    logic [15:0] csum_calc;

`ifdef UDP_TX_CSUM_EN
    logic [15:0] pseudo_q, pseudo_d;
    logic [31:0] acc_q, acc_d;         // wide enough that no carry is lost before the final fold
    logic [31:0] sum_all;
    logic [16:0] fold1;
    logic [15:0] fold2;

    always_comb begin
        sum_all = acc_q + {16'h0, pseudo_q} + {16'h0, hdr_q.src} + {16'h0, hdr_q.dst}
                + {15'h0, len_calc, 1'b0};   // UDP length appears twice in the sum
        fold1   = {1'b0, sum_all[31:16]} + {1'b0, sum_all[15:0]};
        fold2   = fold1[15:0] + {15'h0, fold1[16]};
        // A computed zero must go out as 0xFFFF (0x0000 means "no checksum").
        csum_calc = (fold2 == 16'hFFFF) ? 16'hFFFF : ~fold2;
    end

    always_ff @(posedge i_clk or negedge i_reset_n) begin
        if (!i_reset_n) begin
            pseudo_q <= '0;
            acc_q    <= '0;
        end else begin
            pseudo_q <= pseudo_d;
            acc_q    <= acc_d;
        end
    end
`else
    logic unused_pseudo;
    assign unused_pseudo = ^s_udp_pseudo_sum;
    assign csum_calc     = 16'h0000;
`endif

    assign out_hs   = out_vld_q & m_axis_trdy;
    assign idx_next = idx_q + 3'd1;
    assign len_calc = count_q + 16'(UDP_HDR_LENGTH);

    always_comb begin
        state_d        = state_q;
        hdr_d          = hdr_q;
        count_d        = count_q;
        idx_d          = idx_q;
        out_vld_d      = out_vld_q;
        out_dat_d      = out_dat_q;
        out_last_d     = out_last_q;
        fifo_wr        = 1'b0;
        fifo_rd        = 1'b0;
        fifo_flush     = 1'b0;
        o_drop         = 1'b0;
        s_udp_hdr_trdy = 1'b0;
        s_axis_trdy    = 1'b0;
`ifdef UDP_TX_CSUM_EN
        pseudo_d       = pseudo_q;
        acc_d          = acc_q;
`endif
        case (state_q)
            IDLE: begin
                // rdy_en_q keeps trdy low during reset and rises one cycle after release.
                s_udp_hdr_trdy = rdy_en_q;
                if (rdy_en_q && s_udp_hdr_tvalid) begin
                    hdr_d.src = s_udp_src_port;
                    hdr_d.dst = s_udp_dst_port;
                    count_d   = '0;
`ifdef UDP_TX_CSUM_EN
                    pseudo_d  = s_udp_pseudo_sum;
                    acc_d     = '0;
`endif
                    state_d   = BUFFER;
                end
            end
            BUFFER: begin
                s_axis_trdy = 1'b1;
                if (s_axis_tvalid) begin
                    if (count_q == DEPTH_LIMIT) begin
                        fifo_flush = 1'b1;
                        if (s_axis_tlast) begin
                            o_drop  = 1'b1;
                            state_d = IDLE;
                        end else begin
                            state_d = DROP;
                        end
                    end else begin
                        fifo_wr = 1'b1;
                        count_d = count_q + 16'd1;
`ifdef UDP_TX_CSUM_EN
                        // Even byte positions are the high half of a big-endian word.
                        acc_d = acc_q + (count_q[0] ? {24'h0, s_axis_tdata}
                                                    : {16'h0, s_axis_tdata, 8'h00});
`endif
                        if (s_axis_tlast) state_d = FOLD;
                    end
                end
            end
            FOLD: begin
                hdr_d.len  = len_calc;
                hdr_d.csum = csum_calc;
                // src[15:8] does not depend on the checksum, so it can be loaded now.
                out_vld_d  = 1'b1;
                out_dat_d  = hdr_q.src[15:8];
                out_last_d = 1'b0;
                idx_d      = '0;
                state_d    = HDR;
            end
            HDR: begin
                if (out_hs) begin
                    if (idx_q == LAST_IDX) begin
                        fifo_rd    = 1'b1;
                        out_dat_d  = fifo_rdat;
                        count_d    = count_q - 16'd1;
                        out_last_d = (count_q == 16'd1);
                        state_d    = PAYLOAD;
                    end else begin
                        idx_d     = idx_next;
                        out_dat_d = hdr_byte(hdr_q, idx_next);
                    end
                end
            end
            PAYLOAD: begin
                if (out_hs) begin
                    if (out_last_q) begin
                        out_vld_d  = 1'b0;
                        out_dat_d  = '0;
                        out_last_d = 1'b0;
                        state_d    = IDLE;
                    end else begin
                        fifo_rd    = 1'b1;
                        out_dat_d  = fifo_rdat;
                        count_d    = count_q - 16'd1;
                        out_last_d = (count_q == 16'd1);
                    end
                end
            end
            DROP: begin
                s_axis_trdy = 1'b1;
                fifo_flush  = 1'b1;
                if (s_axis_tvalid && s_axis_tlast) begin
                    o_drop  = 1'b1;
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge i_clk or negedge i_reset_n) begin
        if (!i_reset_n) begin
            state_q    <= IDLE;
            rdy_en_q   <= 1'b0;
            hdr_q      <= '0;
            count_q    <= '0;
            idx_q      <= '0;
            out_vld_q  <= 1'b0;
            out_dat_q  <= '0;
            out_last_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            rdy_en_q   <= 1'b1;
            hdr_q      <= hdr_d;
            count_q    <= count_d;
            idx_q      <= idx_d;
            out_vld_q  <= out_vld_d;
            out_dat_q  <= out_dat_d;
            out_last_q <= out_last_d;
        end
    end

    sync_fifo #(
        .DEPTH (FIFO_DEPTH),
        .WIDTH (8)
    ) u_fifo (
        .i_clk     (i_clk),
        .i_reset_n (i_reset_n),
        .i_flush   (fifo_flush),
        .i_wr_en   (fifo_wr),
        .i_wr_dat  (s_axis_tdata),
        .i_rd_en   (fifo_rd),
        .o_rd_dat  (fifo_rdat)
    );

    assign m_axis_tdata  = out_dat_q;
    assign m_axis_tvalid = out_vld_q;
    assign m_axis_tlast  = out_last_q;

endmodule

// File: tb/tb_udp_tx_buffered.sv
// Directed bench for udp_tx_buffered with a byte scoreboard on the output stream.
// Latency: checks header-valid timing after payload tlast.
// Backpressure: exercises random m_axis_trdy and checks output hold under stall.
module tb_udp_tx_buffered;

    localparam int DEPTH = 64;
`ifdef UDP_TX_CSUM_EN
    localparam bit CSUM_ON = 1'b1;
`else
    localparam bit CSUM_ON = 1'b0;
`endif

    logic        i_clk = 1'b0;
    logic        i_reset_n;
    logic        s_udp_hdr_tvalid;
    logic        s_udp_hdr_trdy;
    logic [15:0] s_udp_src_port;
    logic [15:0] s_udp_dst_port;
    logic [15:0] s_udp_pseudo_sum;
    logic [7:0]  s_axis_tdata;
    logic        s_axis_tvalid;
    logic        s_axis_tlast;
    logic        s_axis_trdy;
    logic [7:0]  m_axis_tdata;
    logic        m_axis_tvalid;
    logic        m_axis_tlast;
    logic        m_axis_trdy;
    logic        o_drop;

    int          total = 0;
    int          bad = 0;
    int          hs_cnt = 0;
    int          drop_cnt = 0;
    bit          rnd_en = 1'b0;
    logic [8:0]  exp_q[$];
    logic [7:0]  pl[$];

    always #5 i_clk = ~i_clk;

    udp_tx_buffered #(
        .AXI_DATA_WIDTH (8),
        .FIFO_DEPTH     (DEPTH)
    ) dut (
        .i_clk            (i_clk),
        .i_reset_n        (i_reset_n),
        .s_udp_hdr_tvalid (s_udp_hdr_tvalid),
        .s_udp_hdr_trdy   (s_udp_hdr_trdy),
        .s_udp_src_port   (s_udp_src_port),
        .s_udp_dst_port   (s_udp_dst_port),
        .s_udp_pseudo_sum (s_udp_pseudo_sum),
        .s_axis_tdata     (s_axis_tdata),
        .s_axis_tvalid    (s_axis_tvalid),
        .s_axis_tlast     (s_axis_tlast),
        .s_axis_trdy      (s_axis_trdy),
        .m_axis_tdata     (m_axis_tdata),
        .m_axis_tvalid    (m_axis_tvalid),
        .m_axis_tlast     (m_axis_tlast),
        .m_axis_trdy      (m_axis_trdy),
        .o_drop           (o_drop)
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        assert (got === exp) else begin
            bad++;
            $error("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Reference one's-complement checksum over pseudo sum, header and the payload in pl.
    function automatic logic [15:0] model_csum(input logic [15:0] src, input logic [15:0] dst,
                                               input logic [15:0] pseudo);
        logic [31:0] s;
        logic [15:0] len;
        logic [15:0] r;
        len = 16'(8 + pl.size());
        s = 32'(pseudo) + 32'(src) + 32'(dst) + 32'(len) + 32'(len);
        for (int i = 0; i < pl.size(); i++)
            s += (i % 2 == 0) ? {16'h0, pl[i], 8'h00} : {24'h0, pl[i]};
        while (s[31:16] != 16'h0) s = {16'h0, s[15:0]} + {16'h0, s[31:16]};
        r = ~s[15:0];
        return (r == 16'h0000) ? 16'hFFFF : r;
    endfunction

    task automatic push_pkt(input logic [15:0] src, input logic [15:0] dst,
                            input logic [15:0] len, input logic [15:0] csum);
        exp_q.push_back({1'b0, src[15:8]});
        exp_q.push_back({1'b0, src[7:0]});
        exp_q.push_back({1'b0, dst[15:8]});
        exp_q.push_back({1'b0, dst[7:0]});
        exp_q.push_back({1'b0, len[15:8]});
        exp_q.push_back({1'b0, len[7:0]});
        exp_q.push_back({1'b0, csum[15:8]});
        exp_q.push_back({1'b0, csum[7:0]});
        for (int i = 0; i < pl.size(); i++)
            exp_q.push_back({(i == pl.size() - 1), pl[i]});
    endtask

    // Returns at posedge+1 just after the tlast byte was accepted.
    task automatic send_pkt(input logic [15:0] src, input logic [15:0] dst,
                            input logic [15:0] pseudo, input bit gaps);
        int guard;
        s_udp_src_port   = src;
        s_udp_dst_port   = dst;
        s_udp_pseudo_sum = pseudo;
        s_udp_hdr_tvalid = 1'b1;
        guard = 0;
        while (!s_udp_hdr_trdy && guard < 200) begin
            @(posedge i_clk); #1;
            guard++;
        end
        chk("hdr_accept_wait", guard < 200, 1);
        @(posedge i_clk); #1;
        s_udp_hdr_tvalid = 1'b0;
        for (int i = 0; i < pl.size(); i++) begin
            if (gaps && $urandom_range(0, 3) == 0) begin
                s_axis_tvalid = 1'b0;
                @(posedge i_clk); #1;
            end
            s_axis_tdata  = pl[i];
            s_axis_tvalid = 1'b1;
            s_axis_tlast  = (i == pl.size() - 1);
            guard = 0;
            while (!s_axis_trdy && guard < 200) begin
                @(posedge i_clk); #1;
                guard++;
            end
            if (guard >= 200) chk("payload_accept_wait", guard, 0);
            @(posedge i_clk); #1;
        end
        s_axis_tvalid = 1'b0;
        s_axis_tlast  = 1'b0;
    endtask

    task automatic drain(input string tag);
        int guard = 0;
        while ((exp_q.size() != 0 || m_axis_tvalid) && guard < 2000) begin
            @(posedge i_clk); #1;
            guard++;
        end
        total++;
        assert (exp_q.size() == 0 && !m_axis_tvalid) else begin
            bad++;
            $error("FAIL %s: drain bound hit, %0d bytes outstanding, expected 0", tag, exp_q.size());
        end
    endtask

    task automatic monitor();
        logic       stall = 1'b0;
        logic [7:0] pdat = '0;
        logic       plast = 1'b0;
        forever begin
            @(negedge i_clk);
            if (!i_reset_n) begin
                stall = 1'b0;
            end else begin
                if (stall)
                    chk("stall_hold", {m_axis_tvalid, m_axis_tlast, m_axis_tdata}, {1'b1, plast, pdat});
                if (m_axis_tvalid && m_axis_trdy) begin
                    total++;
                    assert (exp_q.size() != 0) else begin
                        bad++;
                        $error("FAIL out_unexpected: got byte %02h, expected no output", m_axis_tdata);
                    end
                    if (exp_q.size() != 0)
                        chk("out_byte", {m_axis_tlast, m_axis_tdata}, exp_q.pop_front());
                    hs_cnt++;
                end
                stall = m_axis_tvalid && !m_axis_trdy;
                pdat  = m_axis_tdata;
                plast = m_axis_tlast;
                if (o_drop) drop_cnt++;
            end
        end
    endtask

    task automatic trdy_drv();
        forever begin
            @(posedge i_clk); #1;
            m_axis_trdy = rnd_en ? 1'($urandom_range(0, 1)) : 1'b1;
        end
    endtask

    initial begin
        int base;
        int guard;
        logic [15:0] cs;
        i_reset_n        = 1'b1;
        s_udp_hdr_tvalid = 1'b0;
        s_udp_src_port   = '0;
        s_udp_dst_port   = '0;
        s_udp_pseudo_sum = '0;
        s_axis_tdata     = '0;
        s_axis_tvalid    = 1'b0;
        s_axis_tlast     = 1'b0;
        m_axis_trdy      = 1'b1;
        #2 i_reset_n = 1'b0;
        #1;
        chk("rst_m_tvalid", m_axis_tvalid, 0);
        chk("rst_m_tdata", m_axis_tdata, 0);
        chk("rst_m_tlast", m_axis_tlast, 0);
        chk("rst_hdr_trdy", s_udp_hdr_trdy, 0);
        chk("rst_s_trdy", s_axis_trdy, 0);
        chk("rst_drop", o_drop, 0);
        repeat (3) @(posedge i_clk);
        #1 i_reset_n = 1'b1;
        chk("hdr_trdy_at_release", s_udp_hdr_trdy, 0);
        @(posedge i_clk); #1;
        chk("hdr_trdy_after_release", s_udp_hdr_trdy, 1);
        fork
            monitor();
            trdy_drv();
        join_none

        // Packet A: 4-byte payload, known checksum, latency check.
        pl = '{8'h01, 8'h02, 8'h03, 8'h04};
        push_pkt(16'h1234, 16'h5678, 16'h000C, CSUM_ON ? 16'h9335 : 16'h0000);
        send_pkt(16'h1234, 16'h5678, 16'h0000, 1'b0);
        chk("lat_fold_tvalid", m_axis_tvalid, 0);
        @(posedge i_clk); #1;
        chk("lat_hdr_tvalid", m_axis_tvalid, 1);
        chk("lat_hdr_tdata", m_axis_tdata, 8'h12);
        drain("pkt_a");

        // Packet B: odd payload length, padded final word.
        pl = '{8'hAA, 8'hBB, 8'hCC};
        push_pkt(16'h0001, 16'h0002, 16'h000B, CSUM_ON ? 16'h892A : 16'h0000);
        send_pkt(16'h0001, 16'h0002, 16'h0000, 1'b0);
        drain("pkt_b");

        // Packet C: exactly FIFO-depth payload, random output stalls and input gaps.
        pl.delete();
        for (int i = 0; i < DEPTH; i++) pl.push_back(8'($urandom_range(0, 255)));
        cs = CSUM_ON ? model_csum(16'hC0DE, 16'h0035, 16'hBEEF) : 16'h0000;
        push_pkt(16'hC0DE, 16'h0035, 16'(8 + DEPTH), cs);
        rnd_en = 1'b1;
        send_pkt(16'hC0DE, 16'h0035, 16'hBEEF, 1'b1);
        drain("pkt_c_full_depth");
        rnd_en = 1'b0;
        @(posedge i_clk); #1;

        // Packet D: one byte too many, tlast on the overflowing byte.
        pl.delete();
        for (int i = 0; i < DEPTH + 1; i++) pl.push_back(8'(i));
        base = drop_cnt;
        send_pkt(16'h1111, 16'h2222, 16'h0000, 1'b0);
        repeat (20) @(posedge i_clk);
        #1;
        chk("drop_d_pulses", drop_cnt - base, 1);
        chk("drop_d_no_out", m_axis_tvalid, 0);
        chk("drop_d_idle", s_udp_hdr_trdy, 1);

        // Packet E: overflow well before tlast, discarded through tlast.
        pl.delete();
        for (int i = 0; i < DEPTH + 6; i++) pl.push_back(8'(255 - i));
        base = drop_cnt;
        send_pkt(16'h3333, 16'h4444, 16'h0000, 1'b0);
        repeat (20) @(posedge i_clk);
        #1;
        chk("drop_e_pulses", drop_cnt - base, 1);
        chk("drop_e_no_out", m_axis_tvalid, 0);

        // Packet F: single byte right after drops.
        pl = '{8'h5A};
        cs = CSUM_ON ? model_csum(16'h0A0B, 16'h0C0D, 16'h1111) : 16'h0000;
        push_pkt(16'h0A0B, 16'h0C0D, 16'h0009, cs);
        send_pkt(16'h0A0B, 16'h0C0D, 16'h1111, 1'b0);
        drain("pkt_f_one_byte");

        // Packet G: reset after six header bytes have gone out.
        pl.delete();
        for (int i = 0; i < 10; i++) pl.push_back(8'(8'h30 + i));
        push_pkt(16'hAAAA, 16'h5555, 16'd18, CSUM_ON ? model_csum(16'hAAAA, 16'h5555, 16'h0000) : 16'h0000);
        base = hs_cnt;
        send_pkt(16'hAAAA, 16'h5555, 16'h0000, 1'b0);
        guard = 0;
        while (hs_cnt < base + 6 && guard < 100) begin
            @(posedge i_clk); #1;
            guard++;
        end
        chk("rst_mid_hs_count", hs_cnt - base, 6);
        i_reset_n = 1'b0;
        #1;
        chk("rst_mid_tvalid", m_axis_tvalid, 0);
        chk("rst_mid_tdata", m_axis_tdata, 0);
        chk("rst_mid_tlast", m_axis_tlast, 0);
        chk("rst_mid_hdr_trdy", s_udp_hdr_trdy, 0);
        exp_q.delete();
        repeat (2) @(posedge i_clk);
        #1 i_reset_n = 1'b1;
        repeat (10) @(posedge i_clk);
        #1;
        chk("rst_mid_no_partial", m_axis_tvalid, 0);

        // Packet H: same as A after the reset.
        pl = '{8'h01, 8'h02, 8'h03, 8'h04};
        push_pkt(16'h1234, 16'h5678, 16'h000C, CSUM_ON ? 16'h9335 : 16'h0000);
        send_pkt(16'h1234, 16'h5678, 16'h0000, 1'b0);
        drain("pkt_h_after_reset");

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/udp_tx_buffered.md
UDP_TX_BUFFERED -- requirements
Module: udp_tx_buffered

Interface
REQ-001 Parameter AXI_DATA_WIDTH, default 8, meaning: payload/output byte lane width; any value other than 8 SHALL fail elaboration.
REQ-002 Parameter FIFO_DEPTH, default 2048, meaning: maximum payload bytes buffered; SHALL be a power of two in the range 16..32768.
REQ-003 i_clk  in  1  sole clock; all logic on rising edge.
REQ-004 i_reset_n  in  1  asynchronous assert, active-low reset.
REQ-005 s_udp_hdr_tvalid in 1 / s_udp_hdr_trdy out 1: header handshake.
REQ-006 s_udp_src_port, s_udp_dst_port  in  16 each  header ports.
REQ-007 s_udp_pseudo_sum  in  16  one's-complement sum of src IP, dst IP and protocol (UDP length excluded).
REQ-008 s_axis_tdata in 8, s_axis_tvalid in 1, s_axis_tlast in 1, s_axis_trdy out 1: payload input.
REQ-009 m_axis_tdata out 8, m_axis_tvalid out 1, m_axis_tlast out 1, m_axis_trdy in 1: encapsulated output.
REQ-010 o_drop  out  1  one-cycle pulse when an oversize packet is discarded.

Function
REQ-011 States SHALL be IDLE, BUFFER, FOLD, HDR, PAYLOAD, DROP.
REQ-012 IDLE: s_udp_hdr_trdy=1; on s_udp_hdr_tvalid latch ports and pseudo sum, go BUFFER; s_axis_trdy=0.
REQ-013 BUFFER: s_axis_trdy=1; each accepted byte written to FIFO, 16-bit byte count incremented, checksum accumulated; accepted tlast -> FOLD.
REQ-014 Accepted byte that would exceed FIFO_DEPTH bytes -> DROP without writing it.
REQ-015 DROP: s_axis_trdy=1, discard bytes through tlast, flush FIFO, pulse o_drop on the tlast cycle, return IDLE; nothing emitted.
REQ-016 UDP length SHALL equal 8 + byte count, 16-bit.
REQ-017 FOLD: one cycle; fold carries, complement, go HDR.
REQ-018 HDR: emit src[15:8], src[7:0], dst[15:8], dst[7:0], len[15:8], len[7:0], csum[15:8], csum[7:0]; byte index advances only on m_axis_tvalid & m_axis_trdy.
REQ-019 PAYLOAD: drain FIFO in order; m_axis_tlast=1 only on final payload byte; after its handshake -> IDLE.
REQ-020 First header byte valid exactly 2 cycles after tlast accepted in BUFFER.
REQ-021 m_axis outputs registered; tdata/tlast SHALL hold stable while tvalid=1 and trdy=0; no bubbles while trdy=1.
REQ-022 Checksum: big-endian 16-bit words, odd final byte padded low with 0x00, end-around carry.

Reset
REQ-023 Reset SHALL force IDLE, discard FIFO contents/counters; all outputs 0 (s_udp_hdr_trdy rises first cycle after release).
REQ-024 Reset mid-packet SHALL emit no partial packet after release.

Configuration
REQ-025 UDP_TX_CSUM_EN defined: checksum = ~(pseudo_sum + len + src + dst + len + 0 + payload words); result 0x0000 sent as 0xFFFF.
REQ-026 UDP_TX_CSUM_EN undefined: checksum field 0x0000, accumulator and s_udp_pseudo_sum logic removed.

Structure
REQ-027 Package udp_pkg: UDP_HDR_LENGTH=8, state enum, header-byte index type.
REQ-028 Sub-module sync_fifo (DEPTH, WIDTH=8, first-word-fall-through) SHALL hold payload.

Verification
REQ-029 CSUM_EN, src 0x1234, dst 0x5678, pseudo 0, payload 01 02 03 04 -> 12 34 56 78 00 0C 93 35 01 02 03 04, tlast on 04.
REQ-030 CSUM_EN, src 0x0001, dst 0x0002, pseudo 0, payload AA BB CC -> 00 01 00 02 00 0B 89 2A AA BB CC.
REQ-031 Macro undefined, REQ-029 stimulus -> checksum bytes 00 00, rest identical.
REQ-032 FIFO_DEPTH=16, 17-byte payload -> o_drop single pulse, no output; next 1-byte packet emitted correctly.
REQ-033 Random m_axis_trdy (50%) on 64-byte packet -> byte-exact output, tdata stable under stall.
REQ-034 Reset asserted after 6 header bytes emitted -> outputs 0 immediately; next packet complete and correct.
